// File: rtl/exp_arb_pkg.sv
// Shared constants and types for the exponential-pipeline share arbiter.
package exp_arb_pkg;

  // Default build parameters of the arbiter and the pipeline it fronts.
  localparam int NREQ_DEF     = 2;
  localparam int LAT_DEF      = 12;
  localparam int WIDTHIN_DEF  = 16;
  localparam int WIDTHOUT_DEF = 32;

  // The requester index field is sized for the widest supported build
  // (4 requesters) so one tag type serves every legal NREQ.
  localparam int NREQ_MAX = 4;
  localparam int IDX_W    = $clog2(NREQ_MAX);

  // One slot of the tag line: does this pipeline slot carry an operand,
  // and which requester issued it.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  // Per-requester completion counter.
  typedef logic [15:0] cnt_t;

endpackage

// File: rtl/exp_tag_line.sv
// LAT-deep shift register of tags running in lockstep with the valid chain
// of the shared exponential pipeline. Advances only when enabled, so it
// stalls together with the pipeline.
module exp_tag_line
  import exp_arb_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  tag_t tag_in,
  output tag_t head
);

  tag_t line_q [LAT];
  tag_t line_d [LAT];

  // Next state: on an enabled cycle load the new tag and shift everything
  // one slot toward the head; otherwise hold.
  always_comb begin
    line_d = line_q;
    if (en) begin
      line_d[0] = tag_in;
      for (int i = 1; i < LAT; i++) begin
        line_d[i] = line_q[i-1];
      end
    end
  end

  // State register with synchronous active-low clear of every slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      line_q <= line_d;
    end
  end

  assign head = line_q[LAT-1];

endmodule

// File: rtl/exp_share_arb.sv
// Round-robin front end that shares one exponential pipeline among NREQ
// requesters. A tag line shadows the pipeline so each result is routed back
// to the requester that issued it. A result its owner is not ready to take
// stalls the whole pipeline (pipe_ready doubles as the global stall enable),
// so nothing is dropped or reordered.
//
// Handshake: req_valid/req_ready and rsp_valid/rsp_ready are valid/ready
// pairs; a transfer happens on a rising edge where both are 1. req_ready is
// only ever raised for the single granted requester, and a raised rsp_valid
// holds, with rsp_y stable, until the owner's rsp_ready is seen.
module exp_share_arb
  import exp_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int LAT      = LAT_DEF,
  parameter int WIDTHIN  = WIDTHIN_DEF,
  parameter int WIDTHOUT = WIDTHOUT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTHIN-1:0] req_x,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [WIDTHOUT-1:0]     rsp_y,
  output logic                    pipe_valid,
  output logic [WIDTHIN-1:0]      pipe_x,
  output logic                    pipe_ready,
  input  logic                    pipe_o_valid,
  input  logic [WIDTHOUT-1:0]     pipe_o_y,
  output logic                    err_tag,
  output logic [NREQ*16-1:0]      done_cnt
);

  tag_t             head;
  tag_t             tag_in;
  logic             head_ready;
  logic             en;
  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             err_q, err_d;
  cnt_t             cnt_q [NREQ];
  cnt_t             cnt_d [NREQ];

  // Is the owner of the head slot willing to take its result this cycle.
  always_comb begin
    head_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (head.idx == IDX_W'(i)) head_ready = rsp_ready[i];
    end
  end

  // Global enable: the pipeline advances unless a valid result is waiting
  // on an unready owner. In reset the outputs present the cleared state.
  always_comb begin
    en         = !head.valid || head_ready;
    pipe_ready = en || !reset;
  end

  // Round-robin pick: scan upward from rr_ptr to the top, then wrap and scan
  // from 0 up to rr_ptr. No grant while stalled or in reset.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (reset && en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_any && req_valid[i] && (IDX_W'(i) >= rr_ptr_q)) begin
          grant_any = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_any && req_valid[i] && (IDX_W'(i) < rr_ptr_q)) begin
          grant_any = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
    end
  end

  // Issue side: ready to the winner only, winner's operand to the pipeline
  // (zero when idle), and the tag that follows it down the line.
  always_comb begin
    req_ready = '0;
    pipe_x    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_any && (grant_idx == IDX_W'(i))) begin
        req_ready[i] = 1'b1;
        pipe_x       = req_x[i*WIDTHIN +: WIDTHIN];
      end
    end
    pipe_valid   = grant_any;
    tag_in.valid = grant_any;
    tag_in.idx   = grant_idx;
  end

  // Response side: the pipeline result goes to the requester named by the
  // head tag; the shared bus carries the pipeline output unconditionally.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = reset && head.valid && (head.idx == IDX_W'(i)) && pipe_o_valid;
    end
    rsp_y = pipe_o_y;
  end

  // Next state of pointer, sticky mismatch flag and completion counters.
  // A head whose valid disagrees with the pipeline's o_valid on an enabled
  // cycle means the two chains have drifted apart.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (en && grant_any) begin
      rr_ptr_d = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
    err_d = err_q || (en && (pipe_o_valid != head.valid));
    cnt_d = cnt_q;
    if (en && head.valid) begin
      for (int i = 0; i < NREQ; i++) begin
        if (head.idx == IDX_W'(i)) cnt_d[i] = cnt_q[i] + cnt_t'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Flatten the counters onto the output bus, requester i in slice i.
  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      done_cnt[i*16 +: 16] = cnt_q[i];
    end
  end

  assign err_tag = err_q;

  exp_tag_line #(
    .LAT (LAT)
  ) u_tag_line (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .tag_in (tag_in),
    .head   (head)
  );

endmodule

// File: tb/tb_exp_share_arb.sv
// Directed bench for exp_share_arb with a behavioural stand-in for the
// shared exponential pipeline (fixed LAT, stalls on pipe_ready).
module tb_exp_share_arb;

  localparam int LAT = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [31:0] req_x;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_y;
  logic        pipe_valid;
  logic [15:0] pipe_x;
  logic        pipe_ready;
  logic        pipe_o_valid;
  logic [31:0] pipe_o_y;
  logic        err_tag;
  logic [31:0] done_cnt;
  logic        force_ov;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: {requester, result} in expected completion order.
  logic [33:0] exp_q[$];
  logic [33:0] sb_e;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  exp_share_arb dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_x        (req_x),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_y        (rsp_y),
    .pipe_valid   (pipe_valid),
    .pipe_x       (pipe_x),
    .pipe_ready   (pipe_ready),
    .pipe_o_valid (pipe_o_valid),
    .pipe_o_y     (pipe_o_y),
    .err_tag      (err_tag),
    .done_cnt     (done_cnt)
  );

  // Stand-in result: exp(0) = 1.0 in Q7.25, offset by the operand so every
  // result is distinguishable.
  function automatic logic [31:0] y_of(input logic [15:0] x);
    return 32'h0200_0000 + {16'h0000, x};
  endfunction

  // ---------------- pipeline model ----------------
  logic        pv [LAT];
  logic [31:0] py [LAT];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] <= 1'b0;
        py[i] <= '0;
      end
    end else if (pipe_ready) begin
      pv[0] <= pipe_valid;
      py[0] <= y_of(pipe_x);
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        py[i] <= py[i-1];
      end
    end
  end

  assign pipe_o_valid = pv[LAT-1] | force_ov;
  assign pipe_o_y     = py[LAT-1];

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i]) exp_q.push_back({2'(i), y_of(req_x[i*16 +: 16])});
      end
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL sb_unexpected observed=%0d/%0h expected=none", i, rsp_y);
          end else begin
            sb_e = exp_q.pop_front();
            assert ({2'(i), rsp_y} === sb_e) else begin
              failures++;
              $error("FAIL sb_result observed=%0h expected=%0h", {2'(i), rsp_y}, sb_e);
            end
          end
        end
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset     = 1'b0;
    req_valid = 2'b00;
    req_x     = '0;
    rsp_ready = 2'b11;
    force_ov  = 1'b0;

    // Reset state, with requests pending to prove they are ignored.
    step();
    step();
    req_valid = 2'b11;
    #1;
    chk("reset_req_ready",  64'(req_ready), 64'h0);
    chk("reset_rsp_valid",  64'(rsp_valid), 64'h0);
    chk("reset_pipe_valid", 64'(pipe_valid), 64'h0);
    chk("reset_pipe_ready", 64'(pipe_ready), 64'h1);
    chk("reset_err_tag",    64'(err_tag), 64'h0);
    chk("reset_done_cnt",   64'(done_cnt), 64'h0);

    // Single request: x=0 from requester 0, result 12 cycles later.
    step();
    reset     = 1'b1;
    req_valid = 2'b01;
    req_x     = 32'h0000_0000;
    #1;
    chk("single_req_ready",  64'(req_ready), 64'h1);
    chk("single_pipe_valid", 64'(pipe_valid), 64'h1);
    chk("single_pipe_x",     64'(pipe_x), 64'h0);
    for (int n = 1; n <= 12; n++) begin
      step();
      req_valid = 2'b00;
      #1;
      if (n < 12) begin
        chk("single_early", 64'(rsp_valid), 64'h0);
      end else begin
        chk("single_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("single_rsp_y",     64'(rsp_y), 64'h0200_0000);
      end
    end
    step();
    #1;
    chk("single_done_cnt0", 64'(done_cnt[15:0]), 64'h1);
    chk("single_pulse_end", 64'(rsp_valid), 64'h0);

    // Contention after a fresh reset: alternating grants and returns.
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) step();
      req_valid = (c < 8) ? 2'b11 : 2'b00;
      req_x     = {16'h2000 + 16'(c), 16'h1000 + 16'(c)};
      #1;
      if (c < 8) begin
        chk("cont_grant",  64'(req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
        chk("cont_pipe_x", 64'(pipe_x), (c % 2 == 0) ? 64'(16'h1000 + 16'(c)) : 64'(16'h2000 + 16'(c)));
      end else begin
        chk("cont_nogrant", 64'(req_ready), 64'h0);
      end
      if (c >= 12 && c < 20) chk("cont_rsp", 64'(rsp_valid), (c % 2 == 0) ? 64'h1 : 64'h2);
      else                   chk("cont_rsp_idle", 64'(rsp_valid), 64'h0);
      if (c == 20) chk("cont_done_cnt", 64'(done_cnt), 64'h0004_0004);
    end

    // Backpressure: requester 1 stalls its result for 5 cycles.
    for (int c = 0; c <= 31; c++) begin
      step();
      if (c == 0)       req_valid = 2'b10;
      else if (c <= 17) req_valid = 2'b01;
      else              req_valid = 2'b00;
      req_x     = {16'h0055, 16'h0300 + 16'(c)};
      rsp_ready = (c >= 12 && c <= 16) ? 2'b01 : 2'b11;
      #1;
      if (c == 0) chk("bp_grant1", 64'(req_ready), 64'h2);
      if (c >= 1 && c <= 11) chk("bp_grant0", 64'(req_ready), 64'h1);
      if (c >= 12 && c <= 16) begin
        chk("bp_pipe_ready", 64'(pipe_ready), 64'h0);
        chk("bp_no_grant",   64'(req_ready), 64'h0);
        chk("bp_rsp_valid",  64'(rsp_valid), 64'h2);
        chk("bp_rsp_y",      64'(rsp_y), 64'h0200_0055);
      end
      if (c == 17) begin
        chk("bp_release_rsp",   64'(rsp_valid), 64'h2);
        chk("bp_release_ready", 64'(pipe_ready), 64'h1);
        chk("bp_release_grant", 64'(req_ready), 64'h1);
      end
      if (c >= 18) chk("bp_drain", 64'(rsp_valid), (c <= 29) ? 64'h1 : 64'h0);
      if (c == 31) chk("bp_done_cnt", 64'(done_cnt), 64'h0005_0010);
    end

    // Reset mid-flight with 6 tags in the line.
    for (int c = 0; c < 6; c++) begin
      step();
      req_valid = 2'b01;
      req_x     = {16'h0000, 16'h0400 + 16'(c)};
      #1;
      chk("mf_grant", 64'(req_ready), 64'h1);
    end
    step();
    req_valid = 2'b00;
    reset     = 1'b0;
    #1;
    chk("mf_reset_pipe_ready", 64'(pipe_ready), 64'h1);
    chk("mf_reset_req_ready",  64'(req_ready), 64'h0);
    chk("mf_reset_rsp_valid",  64'(rsp_valid), 64'h0);
    step();
    reset = 1'b1;
    exp_q.delete();
    req_valid = 2'b11;
    req_x     = {16'h0511, 16'h0500};
    #1;
    chk("mf_rr_ptr",   64'(req_ready), 64'h1);
    chk("mf_done_cnt", 64'(done_cnt), 64'h0);
    for (int n = 1; n <= 12; n++) begin
      step();
      req_valid = 2'b00;
      #1;
      chk("mf_no_stale", 64'(rsp_valid), (n == 12) ? 64'h1 : 64'h0);
    end
    step();
    #1;
    chk("mf_done_after", 64'(done_cnt), 64'h0000_0001);

    // Tag mismatch: pipeline claims a result while the head is empty.
    step();
    force_ov = 1'b1;
    #1;
    chk("mm_err_before", 64'(err_tag), 64'h0);
    chk("mm_no_rsp",     64'(rsp_valid), 64'h0);
    step();
    force_ov  = 1'b0;
    req_valid = 2'b10;
    req_x     = {16'h0666, 16'h0000};
    #1;
    chk("mm_err_set", 64'(err_tag), 64'h1);
    for (int n = 1; n <= 14; n++) begin
      step();
      req_valid = 2'b00;
    end
    #1;
    chk("mm_err_persist", 64'(err_tag), 64'h1);
    chk("mm_done_cnt1",   64'(done_cnt[31:16]), 64'h1);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("mm_err_cleared", 64'(err_tag), 64'h0);

    // Counter wrap: 65535 completions, then one more.
    for (int n = 0; n < 65535; n++) begin
      req_valid = 2'b01;
      req_x     = {16'h0000, 16'(n)};
      step();
    end
    req_valid = 2'b00;
    for (int n = 0; n < 12; n++) step();
    #1;
    chk("wrap_ffff", 64'(done_cnt[15:0]), 64'hFFFF);
    req_valid = 2'b01;
    req_x     = {16'h0000, 16'h7777};
    step();
    req_valid = 2'b00;
    for (int n = 0; n < 12; n++) step();
    #1;
    chk("wrap_zero",  64'(done_cnt[15:0]), 64'h0);
    chk("wrap_other", 64'(done_cnt[31:16]), 64'h0);

    step();
    step();
    chk("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
